// File: rtl/instr_fetch_align_pkg.sv
// Shared types for the instruction fetch/align path: fetch FSM states,
// word tags and the compressed-instruction test.
package instr_fetch_align_pkg;

    typedef enum logic [1:0] {
        FSIDLE = 2'd0,
        FSREQ  = 2'd1,
        FSWAIT = 2'd2
    } fetch_state_e;

    typedef logic [29:0] word_tag_t;

    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_fetch_align_word_buffer.sv
// Two-entry tagged word buffer: lookup of the PC word (W) and the next word (N),
// victim choice (invalid slot, then a slot holding neither W nor N) and write port.
module fetch_word_buffer
    import instr_fetch_align_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  word_tag_t   i_tag_w,
    input  word_tag_t   i_tag_n,
    input  logic        i_wr_en,
    input  word_tag_t   i_wr_tag,
    input  logic [31:0] i_wr_data,
    output logic        o_hit_w,
    output logic        o_hit_n,
    output logic [31:0] o_data_w,
    output logic [15:0] o_half_n,
    output logic        o_victim_ok
);

    logic [1:0]  r_valid;
    word_tag_t   r_tag  [2];
    logic [31:0] r_data [2];

    logic [1:0] w_hw;
    logic [1:0] w_hn;
    logic [1:0] w_stale;
    logic       w_victim_sel;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_hw[i]    = r_valid[i] && (r_tag[i] == i_tag_w);
            w_hn[i]    = r_valid[i] && (r_tag[i] == i_tag_n);
            w_stale[i] = r_valid[i] && !w_hw[i] && !w_hn[i];
        end
    end

    assign o_hit_w  = |w_hw;
    assign o_hit_n  = |w_hn;
    assign o_data_w = w_hw[0] ? r_data[0] : r_data[1];
    assign o_half_n = w_hn[0] ? r_data[0][15:0] : r_data[1][15:0];

    // Free slot wins over a stale one; with both slots live the write is dropped.
    assign o_victim_ok  = |(~r_valid | w_stale);
    assign w_victim_sel = !r_valid[0] ? 1'b0 :
                          !r_valid[1] ? 1'b1 :
                          w_stale[0]  ? 1'b0 : 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 2'b00;
        end else if (i_wr_en && o_victim_ok) begin
            r_valid[w_victim_sel] <= 1'b1;
            r_tag[w_victim_sel]   <= i_wr_tag;
            r_data[w_victim_sel]  <= i_wr_data;
        end
    end

endmodule

// File: rtl/instr_fetch_align.sv
// Fetches words into a 2-entry buffer and extracts the (possibly straddling)
// instruction at the halfword-aligned PC, flagging 16-bit forms.
//   state  | meaning
//   FSIDLE | no request in flight; picks the next needed word
//   FSREQ  | MemReq held with MemAddr until MemReady
//   FSWAIT | request accepted, waiting for MemRValid
module instr_fetch_align
    import instr_fetch_align_pkg::*;
#(
    parameter bit PREFETCH = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_addr,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr_data,
    output logic        o_compressed,
    output logic        o_fetch_fault
);

    fetch_state_e r_state;
    word_tag_t    r_req_addr;
    logic         r_mem_req;
    logic [31:0]  r_mem_addr;

    word_tag_t   w_tag_w;
    word_tag_t   w_tag_n;
    logic        w_hit_w;
    logic        w_hit_n;
    logic [31:0] w_data_w;
    logic [15:0] w_half_n;
    logic        w_victim_ok;
    logic [15:0] w_half;
    logic        w_comp;
    logic        w_fault;
    logic        w_need_w;
    logic        w_need_n_str;
    logic        w_need_n_pf;
    logic        w_need;
    word_tag_t   w_need_tag;
    logic        w_wr_en;
    logic        w_valid;
    logic [31:0] w_instr;
    logic        w_comp_out;

    assign w_tag_w = i_pc_addr[31:2];
    assign w_tag_n = w_tag_w + 30'd1;
    assign w_fault = i_pc_addr[0];
    assign w_half  = i_pc_addr[1] ? w_data_w[31:16] : w_data_w[15:0];
    assign w_comp  = is_compressed(w_half);

    // Tag check uses the current PC, so a PC move on the response edge decides the drop.
    assign w_wr_en = (r_state == FSWAIT) && i_mem_rvalid &&
                     ((r_req_addr == w_tag_w) || (r_req_addr == w_tag_n));

    fetch_word_buffer u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tag_w     (w_tag_w),
        .i_tag_n     (w_tag_n),
        .i_wr_en     (w_wr_en),
        .i_wr_tag    (r_req_addr),
        .i_wr_data   (i_mem_rdata),
        .o_hit_w     (w_hit_w),
        .o_hit_n     (w_hit_n),
        .o_data_w    (w_data_w),
        .o_half_n    (w_half_n),
        .o_victim_ok (w_victim_ok)
    );

    assign w_need_w     = !w_hit_w;
    assign w_need_n_str = w_hit_w && i_pc_addr[1] && !w_comp && !w_hit_n;
    assign w_need_n_pf  = PREFETCH && !w_hit_n && w_victim_ok;
    assign w_need       = !w_fault && (w_need_w || w_need_n_str || w_need_n_pf);
    assign w_need_tag   = w_need_w ? w_tag_w : w_tag_n;

    always_comb begin
        w_valid    = 1'b0;
        w_instr    = 32'h0;
        w_comp_out = 1'b0;
        if (!w_fault && w_hit_w) begin
            if (w_comp) begin
                w_valid    = 1'b1;
                w_instr    = {16'h0, w_half};
                w_comp_out = 1'b1;
            end else if (!i_pc_addr[1]) begin
                w_valid = 1'b1;
                w_instr = w_data_w;
            end else if (w_hit_n) begin
                w_valid = 1'b1;
                w_instr = {w_half_n, w_data_w[31:16]};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= FSIDLE;
            r_req_addr <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
        end else begin
            case (r_state)
                FSIDLE: begin
                    if (w_need) begin
                        r_req_addr <= w_need_tag;
                        r_mem_addr <= {w_need_tag, 2'b00};
                        r_mem_req  <= 1'b1;
                        r_state    <= FSREQ;
                    end
                end
                FSREQ: begin
                    if (i_mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= FSWAIT;
                    end
                end
                FSWAIT: begin
                    if (i_mem_rvalid) r_state <= FSIDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= FSIDLE;
                end
            endcase
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_instr_valid = w_valid;
    assign o_instr_data  = w_instr;
    assign o_compressed  = w_comp_out;
    assign o_fetch_fault = w_fault;

endmodule

// File: tb/tb_instr_fetch_align.sv
// Directed bench for instr_fetch_align: a small memory responder plus one task per scenario.
module tb_instr_fetch_align;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        compressed;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [bit [31:0]];
    int          req_cnt [bit [31:0]];
    int          rsp_cnt [bit [31:0]];
    logic [31:0] hs_log  [$];
    bit          rsp_en;
    bit          inject_rv;
    logic [31:0] inject_data;

    always #5 clk = ~clk;

    instr_fetch_align #(.PREFETCH(1'b1)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pc_addr     (pc),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_ready   (mem_ready),
        .i_mem_rvalid  (mem_rvalid),
        .i_mem_rdata   (mem_rdata),
        .o_instr_valid (instr_valid),
        .o_instr_data  (instr_data),
        .o_compressed  (compressed),
        .o_fetch_fault (fetch_fault)
    );

    function automatic logic [31:0] mem_rd(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic int reqs(input bit [31:0] a);
        if (req_cnt.exists(a)) return req_cnt[a];
        return 0;
    endfunction

    function automatic int rsps(input bit [31:0] a);
        if (rsp_cnt.exists(a)) return rsp_cnt[a];
        return 0;
    endfunction

    // Memory: a handshake seen in one cycle is answered in the next when rsp_en is set.
    initial begin
        bit          hs;
        logic [31:0] a;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            hs = mem_req && mem_ready;
            a  = mem_addr;
            @(posedge clk);
            if (hs) begin
                req_cnt[a] = reqs(a) + 1;
                hs_log.push_back(a);
            end
            #1;
            if (inject_rv) begin
                mem_rvalid = 1'b1;
                mem_rdata  = inject_data;
            end else if (hs && rsp_en) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_rd(a);
                rsp_cnt[a] = rsps(a) + 1;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 32'h0; mem_ready = 1'b1; rsp_en = 1'b1;
        inject_rv = 1'b0; inject_data = 32'h0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr} !== 33'h0) begin
            errors++;
            $display("FAIL reset_mem: req=%0b addr=%h expected 0/00000000", mem_req, mem_addr);
        end
        checks++;
        if ({instr_valid, instr_data, compressed} !== 34'h0) begin
            errors++;
            $display("FAIL reset_instr: valid=%0b data=%h c=%0b expected all 0", instr_valid, instr_data, compressed);
        end
    endtask

    task automatic test_miss_latency();
        step(); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL lat_c0_req: got %0b expected 0", mem_req); end
        step(); @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL lat_c1_req: req=%0b addr=%h expected 1/00000000", mem_req, mem_addr);
        end
        step(); @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat_c2_valid: got %0b expected 0", instr_valid); end
        step(); @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 32'h00000513 || compressed !== 1'b0) begin
            errors++;
            $display("FAIL lat_c3_instr: valid=%0b data=%h c=%0b expected 1/00000513/0", instr_valid, instr_data, compressed);
        end
        repeat (8) step();
        checks++;
        if (reqs(32'h0) !== 1) begin errors++; $display("FAIL lat_req_count: got %0d expected 1", reqs(32'h0)); end
    endtask

    task automatic test_compressed_pair();
        bit ok;
        step(); pc = 32'h100;
        wait_valid(ok);
        checks++;
        if (!ok || instr_data !== 32'h00004581 || compressed !== 1'b1) begin
            errors++;
            $display("FAIL c_lo: valid=%0b data=%h c=%0b expected 1/00004581/1", instr_valid, instr_data, compressed);
        end
        step(); pc = 32'h102;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_data !== 32'h00004501 || compressed !== 1'b1) begin
            errors++;
            $display("FAIL c_hi: valid=%0b data=%h c=%0b expected 1/00004501/1", instr_valid, instr_data, compressed);
        end
        repeat (8) step();
        checks++;
        if (reqs(32'h100) !== 1) begin errors++; $display("FAIL c_refetch: reqs(100)=%0d expected 1", reqs(32'h100)); end
    endtask

    task automatic test_straddle();
        bit ok;
        step(); pc = 32'h202;
        wait_valid(ok);
        checks++;
        if (!ok || rsps(32'h204) < 1) begin
            errors++;
            $display("FAIL str_order: valid=%0b rsps(204)=%0d expected valid only after 204 stored", instr_valid, rsps(32'h204));
        end
        checks++;
        if (instr_data !== 32'h00000513 || compressed !== 1'b0) begin
            errors++; $display("FAIL str_data: data=%h c=%0b expected 00000513/0", instr_data, compressed);
        end
    endtask

    task automatic test_ready_stall();
        repeat (8) step();
        mem_ready = 1'b0; rsp_en = 1'b0; pc = 32'h300;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_c0: req=%0b expected 0", mem_req); end
        for (int i = 0; i < 3; i++) begin
            step(); @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
                errors++; $display("FAIL stall_hold%0d: req=%0b addr=%h expected 1/00000300", i, mem_req, mem_addr);
            end
        end
        step(); mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL stall_accept: req=%0b expected 1", mem_req); end
        step(); @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h300) begin
            errors++; $display("FAIL stall_wait: req=%0b addr=%h expected 0/00000300", mem_req, mem_addr);
        end
    endtask

    task automatic test_stale_drop();
        bit ok;
        step(); pc = 32'h800;
        step(); @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL stale_wait: req=%0b valid=%0b expected 0/0", mem_req, instr_valid);
        end
        hs_log.delete();
        inject_data = mem_rd(32'h300);
        inject_rv   = 1'b1;
        @(negedge clk);
        inject_rv = 1'b0;
        rsp_en    = 1'b1;
        wait_valid(ok);
        checks++;
        if (!ok || instr_data !== 32'h00A00093 || compressed !== 1'b0) begin
            errors++;
            $display("FAIL stale_instr: valid=%0b data=%h c=%0b expected 1/00A00093/0", instr_valid, instr_data, compressed);
        end
        checks++;
        if (hs_log.size() == 0 || hs_log[0] !== 32'h800 || reqs(32'h300) !== 1) begin
            errors++;
            $display("FAIL stale_next_req: first=%h reqs(300)=%0d expected 00000800/1",
                     (hs_log.size() == 0) ? 32'hx : hs_log[0], reqs(32'h300));
        end
    endtask

    task automatic test_fault_and_reset();
        bit ok;
        int n;
        repeat (8) step();
        n = hs_log.size();
        pc = 32'h101;
        @(negedge clk);
        checks++;
        if (fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL fault_flag: fault=%0b valid=%0b expected 1/0", fetch_fault, instr_valid);
        end
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || hs_log.size() != n) begin
            errors++; $display("FAIL fault_noreq: req=%0b new_reqs=%0d expected 0/0", mem_req, hs_log.size() - n);
        end
        step(); pc = 32'h400; rsp_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_req_timeout: req=%0b expected 1", mem_req); end
        step(); rst = 1'b1; pc = 32'h101;
        step(); step(); rst = 1'b0;
        @(negedge clk);
        inject_data = 32'hDEADBEEF;
        inject_rv   = 1'b1;
        @(negedge clk);
        inject_rv = 1'b0;
        step(); @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, instr_valid, instr_data, compressed} !== 67'h0) begin
            errors++;
            $display("FAIL late_rsp: req=%0b addr=%h valid=%0b data=%h c=%0b expected all 0",
                     mem_req, mem_addr, instr_valid, instr_data, compressed);
        end
        step(); pc = 32'h400; rsp_en = 1'b1;
        wait_valid(ok);
        checks++;
        if (!ok || instr_data !== 32'h00004505 || compressed !== 1'b1 || reqs(32'h400) !== 2) begin
            errors++;
            $display("FAIL post_rst: valid=%0b data=%h c=%0b reqs(400)=%0d expected 1/00004505/1/2",
                     instr_valid, instr_data, compressed, reqs(32'h400));
        end
    endtask

    initial begin
        mem[32'h000] = 32'h00000513;
        mem[32'h100] = 32'h45014581;
        mem[32'h200] = 32'h05134581;
        mem[32'h204] = 32'h12340000;
        mem[32'h300] = 32'h0000A5A5;
        mem[32'h400] = 32'h00004505;
        mem[32'h800] = 32'h00A00093;
        test_reset();
        test_miss_latency();
        test_compressed_pair();
        test_straddle();
        test_ready_stall();
        test_stale_drop();
        test_fault_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
